acc_result_buffer: RTL and testbench

- Output stage directly downstream of the systolic array's result de-skew (result_sync) path.
- Captures one MATRIX_SIZE-lane row of de-skewed partial sums per beat into an addressed accumulator file, either overwriting or accumulating (K-tiling across weight reloads).
- On command, drains a range of entries through shift/saturate requantisation to DATA_BW lanes over a valid/ready stream, for write-back to the unified buffer.

---
 rtl/acc_result_buffer_pkg.sv | 29 ++
 rtl/acc_requant_lane.sv | 36 +++
 rtl/acc_result_buffer.sv | 134 +++++++++++++
 tb/tb_acc_result_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_result_buffer_pkg.sv
// rtl/acc_result_buffer_pkg.sv - shared state encoding, derived widths and saturation bounds
package acc_result_buffer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Entry address width: ADDR_W = $clog2(ACC_DEPTH)
    function automatic int acc_addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Drain count width: CNT_W = ADDR_W + 1, so that a full-depth count fits
    function automatic int acc_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Largest value representable in a signed lane of width bw
    function automatic int sat_max(input int bw);
        return (1 << (bw - 1)) - 1;
    endfunction

    // Smallest value representable in a signed lane of width bw
    function automatic int sat_min(input int bw);
        return -(1 << (bw - 1));
    endfunction

endpackage

// File: rtl/acc_requant_lane.sv
// rtl/acc_requant_lane.sv - one-lane shift, optional ReLU (ACC_RELU_EN), signed saturate
module acc_requant_lane
    import acc_result_buffer_pkg::*;
#(
    parameter int ACC_BW    = 32,
    parameter int DATA_BW   = 8,
    parameter int OUT_SHIFT = 4
) (
    input  logic signed [ACC_BW-1:0]  acc,
    output logic signed [DATA_BW-1:0] q
);

    localparam logic signed [ACC_BW-1:0] SAT_HI = ACC_BW'(sat_max(DATA_BW));
    localparam logic signed [ACC_BW-1:0] SAT_LO = ACC_BW'(sat_min(DATA_BW));

    logic signed [ACC_BW-1:0] v;

    // Arithmetic shift, clip negatives when ReLU is built in, then clamp to the output range
    always_comb begin
        v = acc >>> OUT_SHIFT;
`ifdef ACC_RELU_EN
        if (v[ACC_BW-1]) begin
            v = '0;
        end
`else
`endif
        if (v > SAT_HI) begin
            q = SAT_HI[DATA_BW-1:0];
        end else if (v < SAT_LO) begin
            q = SAT_LO[DATA_BW-1:0];
        end else begin
            q = v[DATA_BW-1:0];
        end
    end

endmodule

// File: rtl/acc_result_buffer.sv
// rtl/acc_result_buffer.sv - addressed accumulator file with requantising drain stream (ACC_RELU_EN optional)
module acc_result_buffer
    import acc_result_buffer_pkg::*;
#(
    parameter int PARTIAL_SUM_BW = 20,
    parameter int MATRIX_SIZE    = 8,
    parameter int ACC_BW         = 32,
    parameter int ACC_DEPTH      = 16,
    parameter int DATA_BW        = 8,
    parameter int OUT_SHIFT      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
    input  logic [acc_addr_w(ACC_DEPTH)-1:0]      in_addr,
    input  logic                                  in_accumulate,
    input  logic                                  drain_start,
    input  logic [acc_addr_w(ACC_DEPTH)-1:0]      drain_base,
    input  logic [acc_cnt_w(ACC_DEPTH)-1:0]       drain_count,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_BW*MATRIX_SIZE-1:0]        out_data,
    output logic                                  drain_done,
    output logic                                  drop_err
);

    localparam int ADDR_W = acc_addr_w(ACC_DEPTH);
    localparam int CNT_W  = acc_cnt_w(ACC_DEPTH);

    logic signed [ACC_BW-1:0] acc_mem [ACC_DEPTH][MATRIX_SIZE];
    logic signed [ACC_BW-1:0] sext_row [MATRIX_SIZE];
    logic signed [ACC_BW-1:0] wr_row [MATRIX_SIZE];
    logic signed [DATA_BW-1:0] q_lane [MATRIX_SIZE];

    state_t             state, state_next;
    logic [ADDR_W-1:0]  rd_ptr, rd_ptr_next;
    logic [CNT_W-1:0]   remaining, remaining_next;
    logic [CNT_W-1:0]   count_clamped;
    logic               done_next, drop_next;
    logic               wr_en;

    assign in_ready      = (state == ST_IDLE);
    assign out_valid     = (state == ST_DRAIN);
    assign wr_en         = in_valid && (state == ST_IDLE);
    assign count_clamped = (drain_count > CNT_W'(ACC_DEPTH)) ? CNT_W'(ACC_DEPTH) : drain_count;

    // Sign-extend each incoming lane and form the overwrite/accumulate result for the target entry
    always_comb begin
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            sext_row[i] = ACC_BW'(signed'(in_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]));
            wr_row[i]   = in_accumulate ? acc_mem[in_addr][i] + sext_row[i] : sext_row[i];
        end
    end

    // Accumulator file: cleared on reset, written only while accepting rows in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < ACC_DEPTH; e++) begin
                for (int i = 0; i < MATRIX_SIZE; i++) begin
                    acc_mem[e][i] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                acc_mem[in_addr][i] <= wr_row[i];
            end
        end
    end

    // Drain sequencing: next state, read pointer, beats remaining, done pulse and sticky drop flag
    always_comb begin
        state_next     = state;
        rd_ptr_next    = rd_ptr;
        remaining_next = remaining;
        done_next      = 1'b0;
        drop_next      = drop_err;
        case (state)
            ST_IDLE: begin
                if (drain_start && (drain_count != '0)) begin
                    state_next     = ST_DRAIN;
                    rd_ptr_next    = drain_base;
                    remaining_next = count_clamped;
                end
            end
            ST_DRAIN: begin
                if (in_valid) begin
                    drop_next = 1'b1;
                end
                if (out_ready) begin
                    if (remaining == CNT_W'(1)) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        rd_ptr_next    = rd_ptr + ADDR_W'(1);
                        remaining_next = remaining - CNT_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Control registers; a reset during a drain abandons it without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rd_ptr     <= '0;
            remaining  <= '0;
            drain_done <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            state      <= state_next;
            rd_ptr     <= rd_ptr_next;
            remaining  <= remaining_next;
            drain_done <= done_next;
            drop_err   <= drop_next;
        end
    end

    for (genvar g = 0; g < MATRIX_SIZE; g++) begin : g_lane
        acc_requant_lane #(
            .ACC_BW    (ACC_BW),
            .DATA_BW   (DATA_BW),
            .OUT_SHIFT (OUT_SHIFT)
        ) u_requant (
            .acc (acc_mem[rd_ptr][g]),
            .q   (q_lane[g])
        );
        assign out_data[g*DATA_BW +: DATA_BW] = out_valid ? q_lane[g] : '0;
    end

endmodule

// File: tb/tb_acc_result_buffer.sv
// tb/tb_acc_result_buffer.sv - self-checking bench for acc_result_buffer against a lane-level reference model
module tb_acc_result_buffer;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [159:0] in_data;
    logic [3:0]   in_addr;
    logic         in_accumulate;
    logic         drain_start;
    logic [3:0]   drain_base;
    logic [4:0]   drain_count;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         drain_done;
    logic         drop_err;

    int          model [16][8];
    bit          exp_drop;
    int          n_asserts;
    int          n_fail;
    logic [63:0] first_beat;
    logic [63:0] last_beat;
    int          lanes [8];

    acc_result_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_addr       (in_addr),
        .in_accumulate (in_accumulate),
        .drain_start   (drain_start),
        .drain_base    (drain_base),
        .drain_count   (drain_count),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .drain_done    (drain_done),
        .drop_err      (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rand_lane();
        return int'($urandom_range(0, 1048575)) - 524288;
    endfunction

    // Requantised beat the specification predicts for one model entry
    function automatic logic [63:0] model_beat(input int e);
        logic [63:0] b;
        int v;
        for (int i = 0; i < 8; i++) begin
            v = model[e][i] >>> 4;
`ifdef ACC_RELU_EN
            if (v < 0) v = 0;
`endif
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            b[i*8 +: 8] = v[7:0];
        end
        return b;
    endfunction

    task automatic clear_model();
        for (int e = 0; e < 16; e++)
            for (int i = 0; i < 8; i++)
                model[e][i] = 0;
        exp_drop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_model();
    endtask

    task automatic set_lanes(input int v);
        for (int i = 0; i < 8; i++) lanes[i] = v;
    endtask

    task automatic drive_row(input int addr, input bit acc);
        for (int i = 0; i < 8; i++) in_data[i*20 +: 20] = lanes[i][19:0];
        in_addr       = addr[3:0];
        in_accumulate = acc;
        in_valid      = 1'b1;
    endtask

    task automatic model_write(input int addr);
        for (int i = 0; i < 8; i++)
            model[addr][i] = in_accumulate ? model[addr][i] + lanes[i] : lanes[i];
    endtask

    task automatic write_row(input int addr, input bit acc);
        drive_row(addr, acc);
        tick();
        in_valid = 1'b0;
        model_write(addr);
    endtask

    // pat_len == 0 selects random out_ready and random spurious drain_start pulses
    task automatic do_drain(input int base, input int count, input logic [31:0] pat,
                            input int pat_len, input bit drop);
        int n, idx, cyc;
        n = (count > 16) ? 16 : count;
        drain_base  = base[3:0];
        drain_count = count[4:0];
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        if (n == 0) begin
            chk("zero_count_valid", out_valid, 1'b0);
            chk("zero_count_ready", in_ready, 1'b1);
            return;
        end
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 400) begin
            chk("drain_valid", out_valid, 1'b1);
            chk("drain_in_ready", in_ready, 1'b0);
            chk("drain_done_early", drain_done, 1'b0);
            chk("drain_data", out_data, model_beat((base + idx) % 16));
            if (idx == 0) first_beat = out_data;
            last_beat = out_data;
            if (drop && cyc == 0) begin
                set_lanes(rand_lane());
                drive_row(base, 1'b0);
                exp_drop = 1'b1;
            end
            if (pat_len == 0) begin
                out_ready   = $urandom_range(0, 1);
                drain_start = ($urandom_range(0, 3) == 0);
                drain_base  = 4'($urandom_range(0, 15));
            end else begin
                out_ready = pat[cyc % pat_len];
            end
            if (out_ready) idx++;
            tick();
            in_valid    = 1'b0;
            drain_start = 1'b0;
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_transfers", 64'(idx), 64'(n));
        chk("after_valid", out_valid, 1'b0);
        chk("after_done", drain_done, 1'b1);
        chk("after_drop", drop_err, exp_drop);
        tick();
        chk("done_pulse_end", drain_done, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        in_addr       = '0;
        in_accumulate = 1'b0;
        drain_start   = 1'b0;
        drain_base    = '0;
        drain_count   = '0;
        out_ready     = 1'b0;
        n_asserts     = 0;
        n_fail        = 0;
        do_reset();

        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_drain_done", drain_done, 1'b0);
        chk("rst_drop_err", drop_err, 1'b0);

        set_lanes(100);
        write_row(3, 1'b0);
        set_lanes(-30);
        write_row(3, 1'b1);
        do_drain(3, 1, 32'hffffffff, 32, 1'b0);
        chk("ovr_acc_beat", first_beat, {8{8'h04}});

        set_lanes(0);
        lanes[0] = 524287;
        lanes[1] = -524288;
        write_row(7, 1'b0);
        do_drain(7, 1, 32'hffffffff, 32, 1'b0);
        chk("sat_hi", first_beat[7:0], 8'h7f);
`ifdef ACC_RELU_EN
        chk("sat_lo_relu", first_beat[15:8], 8'h00);
`else
        chk("sat_lo", first_beat[15:8], 8'h80);
`endif

        set_lanes(16);
        write_row(14, 1'b0);
        set_lanes(32);
        write_row(15, 1'b0);
        set_lanes(48);
        write_row(0, 1'b0);
        do_drain(14, 3, 32'b1101, 4, 1'b0);
        chk("wrap_first", first_beat, {8{8'h01}});
        chk("wrap_last", last_beat, {8{8'h03}});

        do_drain(3, 2, 32'b0110, 4, 1'b1);
        do_drain(3, 1, 32'hffffffff, 32, 1'b0);
        chk("drop_entry_kept", first_beat, {8{8'h04}});
        chk("drop_sticky", drop_err, 1'b1);

        set_lanes(64);
        drive_row(5, 1'b0);
        drain_base  = 4'd5;
        drain_count = 5'd1;
        drain_start = 1'b1;
        out_ready   = 1'b1;
        tick();
        in_valid    = 1'b0;
        drain_start = 1'b0;
        model_write(5);
        chk("same_valid", out_valid, 1'b1);
        chk("same_beat", out_data, {8{8'h04}});
        tick();
        out_ready = 1'b0;
        chk("same_done", drain_done, 1'b1);
        chk("same_valid_end", out_valid, 1'b0);
        tick();
        chk("same_done_end", drain_done, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 10; w++) begin
                for (int i = 0; i < 8; i++) lanes[i] = rand_lane();
                write_row(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
            do_drain(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), 32'h0, 0, 1'b0);
        end
        do_drain(int'($urandom_range(0, 15)), 0, 32'h0, 0, 1'b0);
        do_drain(int'($urandom_range(0, 15)), 20, 32'h0, 0, 1'b0);
        chk("drop_still_set", drop_err, 1'b1);

        drain_base  = 4'd0;
        drain_count = 5'd4;
        drain_start = 1'b1;
        out_ready   = 1'b1;
        tick();
        drain_start = 1'b0;
        chk("mid_valid", out_valid, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        clear_model();
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_done", drain_done, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_drop", drop_err, 1'b0);
        tick();
        chk("mid_rst_no_done", drain_done, 1'b0);
        do_drain(0, 16, 32'hffffffff, 32, 1'b0);
        chk("cleared_last", last_beat, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
